// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use interlock, flush bubbling and a
// saturating bubble counter for performance debug.
module id_ex_stage #(
  parameter int unsigned CNT_W  = 16,
  parameter logic [5:0]  NOP_OP = 6'b000000
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dmem_wait,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [5:0]       id_op,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       id_wsel,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic [3:0]       id_aluop,
  input  logic [31:0]      id_rdat1,
  input  logic [31:0]      id_rdat2,
  input  logic [31:0]      id_imm,
  input  logic [31:0]      id_npc,
  output logic             ex_valid,
  output logic [5:0]       ex_op,
  output logic [4:0]       Rs_EX,
  output logic [4:0]       Rt_EX,
  output logic [4:0]       Wsel_ex,
  output logic             RegWrite_ex,
  output logic             MemRead_ex,
  output logic             MemWrite_ex,
  output logic [3:0]       ex_aluop,
  output logic [31:0]      ex_rdat1,
  output logic [31:0]      ex_rdat2,
  output logic [31:0]      ex_imm,
  output logic [31:0]      ex_npc,
  output logic             lu_stall,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [0:0] {StRun, StLuBubble} state_e;

  state_e state_q;
  logic   flush_pend_q;
  logic   adv;
  logic   lu_hit;
  logic   take_flush;
  logic   take_lu;
  logic   load_bubble;
  logic   cnt_inc;

  assign adv = ihit & ~dmem_wait;

  assign lu_hit = MemRead_ex & ex_valid & (Wsel_ex != 5'd0) &
                  ((id_rs == Wsel_ex) | (id_uses_rt & (id_rt == Wsel_ex))) &
                  id_valid & ~flush & ~flush_pend_q;

  // Asserted even while frozen so IF/ID keeps holding the dependent instruction.
  assign lu_stall = lu_hit & (state_q == StRun);

  always_comb begin
    take_flush  = flush | flush_pend_q;
    take_lu     = ~take_flush & lu_stall;
    load_bubble = take_flush | take_lu | ~id_valid;
    cnt_inc     = (take_flush | take_lu) & ~(&bubble_cnt);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= StRun;
      flush_pend_q <= 1'b0;
      bubble_cnt   <= '0;
      ex_valid     <= 1'b0;
      ex_op        <= NOP_OP;
      Rs_EX        <= '0;
      Rt_EX        <= '0;
      Wsel_ex      <= '0;
      RegWrite_ex  <= 1'b0;
      MemRead_ex   <= 1'b0;
      MemWrite_ex  <= 1'b0;
      ex_aluop     <= '0;
      ex_rdat1     <= '0;
      ex_rdat2     <= '0;
      ex_imm       <= '0;
      ex_npc       <= '0;
    end else if (adv) begin
      state_q      <= take_lu ? StLuBubble : StRun;
      flush_pend_q <= 1'b0;
      if (cnt_inc) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
      if (load_bubble) begin
        ex_valid    <= 1'b0;
        ex_op       <= NOP_OP;
        Rs_EX       <= '0;
        Rt_EX       <= '0;
        Wsel_ex     <= '0;
        RegWrite_ex <= 1'b0;
        MemRead_ex  <= 1'b0;
        MemWrite_ex <= 1'b0;
        ex_aluop    <= '0;
        ex_rdat1    <= '0;
        ex_rdat2    <= '0;
        ex_imm      <= '0;
        ex_npc      <= '0;
      end else begin
        ex_valid    <= 1'b1;
        ex_op       <= id_op;
        Rs_EX       <= id_rs;
        Rt_EX       <= id_rt;
        Wsel_ex     <= id_wsel;
        RegWrite_ex <= id_regwrite;
        MemRead_ex  <= id_memread;
        MemWrite_ex <= id_memwrite;
        ex_aluop    <= id_aluop;
        ex_rdat1    <= id_rdat1;
        ex_rdat2    <= id_rdat2;
        ex_imm      <= id_imm;
        ex_npc      <= id_npc;
      end
    end else if (flush) begin
      // Redirect seen while frozen: remember it for the next advancing edge.
      flush_pend_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// compared against a transaction-level model of the EX register.
module tb_id_ex_stage;

  localparam int unsigned CNT_W   = 5;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [5:0]  NOP_OP  = 6'b000000;

  typedef struct packed {
    logic        valid;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wsel;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [3:0]  aluop;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [31:0] npc;
  } ex_t;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic ihit = 1'b0, dmem_wait = 1'b0, flush = 1'b0, id_valid = 1'b0;
  logic [5:0] id_op = '0;
  logic [4:0] id_rs = '0, id_rt = '0, id_wsel = '0;
  logic id_uses_rt = 1'b0, id_regwrite = 1'b0, id_memread = 1'b0, id_memwrite = 1'b0;
  logic [3:0] id_aluop = '0;
  logic [31:0] id_rdat1 = '0, id_rdat2 = '0, id_imm = '0, id_npc = '0;

  logic ex_valid, RegWrite_ex, MemRead_ex, MemWrite_ex, lu_stall;
  logic [5:0] ex_op;
  logic [4:0] Rs_EX, Rt_EX, Wsel_ex;
  logic [3:0] ex_aluop;
  logic [31:0] ex_rdat1, ex_rdat2, ex_imm, ex_npc;
  logic [CNT_W-1:0] bubble_cnt;

  id_ex_stage #(.CNT_W(CNT_W), .NOP_OP(NOP_OP)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dmem_wait(dmem_wait), .flush(flush),
    .id_valid(id_valid), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_wsel(id_wsel), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_aluop(id_aluop),
    .id_rdat1(id_rdat1), .id_rdat2(id_rdat2), .id_imm(id_imm), .id_npc(id_npc),
    .ex_valid(ex_valid), .ex_op(ex_op), .Rs_EX(Rs_EX), .Rt_EX(Rt_EX),
    .Wsel_ex(Wsel_ex), .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex),
    .MemWrite_ex(MemWrite_ex), .ex_aluop(ex_aluop), .ex_rdat1(ex_rdat1),
    .ex_rdat2(ex_rdat2), .ex_imm(ex_imm), .ex_npc(ex_npc), .lu_stall(lu_stall),
    .bubble_cnt(bubble_cnt)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: what EX should contain, plus pending-redirect and
  // "the held instruction already paid its load-use bubble" flags.
  ex_t m_ex;
  bit  m_pend;
  bit  m_paid;
  int  m_cnt;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ex_t bubble();
    ex_t b;
    b    = '0;
    b.op = NOP_OP;
    return b;
  endfunction

  function automatic ex_t dut_ex();
    ex_t o;
    o = '{ex_valid, ex_op, Rs_EX, Rt_EX, Wsel_ex, RegWrite_ex, MemRead_ex, MemWrite_ex,
          ex_aluop, ex_rdat1, ex_rdat2, ex_imm, ex_npc};
    return o;
  endfunction

  function automatic bit model_hazard();
    bit dep;
    dep = (id_rs == m_ex.wsel) || (id_uses_rt && id_rt == m_ex.wsel);
    return m_ex.valid && m_ex.mr && m_ex.wsel != 0 && dep && id_valid &&
           !flush && !m_pend && !m_paid;
  endfunction

  task automatic model_reset();
    m_ex   = bubble();
    m_pend = 0;
    m_paid = 0;
    m_cnt  = 0;
  endtask

  task automatic model_step();
    bit haz;
    haz = model_hazard();
    if (ihit && !dmem_wait) begin
      if (flush || m_pend) begin
        m_ex   = bubble();
        m_pend = 0;
        m_paid = 0;
        if (m_cnt < CNT_MAX) m_cnt++;
      end else if (haz) begin
        m_ex  = bubble();
        m_paid = 1;
        if (m_cnt < CNT_MAX) m_cnt++;
      end else begin
        m_paid = 0;
        if (id_valid)
          m_ex = '{1'b1, id_op, id_rs, id_rt, id_wsel, id_regwrite, id_memread,
                   id_memwrite, id_aluop, id_rdat1, id_rdat2, id_imm, id_npc};
        else
          m_ex = bubble();
      end
    end else if (flush) begin
      m_pend = 1;
    end
  endtask

  // One clock: inputs are already driven; check the comb stall, take the edge, check state.
  task automatic cycle();
    #1;
    check("lu_stall", 160'(lu_stall), 160'(model_hazard()));
    @(posedge CLK);
    model_step();
    #1;
    check("ex_regs", 160'(dut_ex()), 160'(m_ex));
    check("bubble_cnt", 160'(bubble_cnt), 160'(m_cnt));
  endtask

  task automatic set_id(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic ur, input logic [4:0] ws, input logic rw,
                        input logic mr, input logic mw);
    id_valid = 1; id_op = op; id_rs = rs; id_rt = rt; id_uses_rt = ur; id_wsel = ws;
    id_regwrite = rw; id_memread = mr; id_memwrite = mw; id_aluop = 4'(op);
    id_rdat1 = $urandom; id_rdat2 = $urandom; id_imm = $urandom; id_npc = $urandom;
  endtask

  task automatic do_reset();
    nRST = 0;
    ihit = 0; dmem_wait = 0; flush = 0; id_valid = 0;
    #1;
    model_reset();
    check("reset_regs", 160'(dut_ex()), 160'(bubble()));
    check("reset_cnt", 160'(bubble_cnt), 160'(0));
    #1;
    nRST = 1;
  endtask

  initial begin
    model_reset();
    #12;
    do_reset();

    // ADD captured on the first advancing edge
    set_id(6'd0, 5'd2, 5'd3, 1, 5'd4, 1, 0, 0); ihit = 1;
    cycle();
    check("t1_rs", 160'(Rs_EX), 160'(2));
    check("t1_rt", 160'(Rt_EX), 160'(3));
    check("t1_wsel", 160'(Wsel_ex), 160'(4));
    check("t1_valid_rw", 160'({ex_valid, RegWrite_ex}), 160'(2'b11));

    // LW r5 then dependent ADD: exactly one bubble
    set_id(6'h23, 5'd1, 5'd5, 0, 5'd5, 1, 1, 0);
    cycle();
    set_id(6'd0, 5'd5, 5'd6, 1, 5'd7, 1, 0, 0);
    #1 check("t2_stall", 160'(lu_stall), 160'(1));
    cycle();
    check("t2_bubble", 160'({ex_valid, ex_op}), 160'({1'b0, NOP_OP}));
    check("t2_cnt", 160'(bubble_cnt), 160'(1));
    check("t2_stall_off", 160'(lu_stall), 160'(0));
    cycle();
    check("t2_add", 160'({ex_valid, Rs_EX}), 160'({1'b1, 5'd5}));

    // SW reading rt of a load: stalls only when id_uses_rt is set
    set_id(6'h23, 5'd1, 5'd5, 0, 5'd5, 1, 1, 0);
    cycle();
    set_id(6'h2b, 5'd9, 5'd5, 1, 5'd0, 0, 0, 1);
    #1 check("t3_sw_stall", 160'(lu_stall), 160'(1));
    cycle(); cycle();
    set_id(6'h23, 5'd1, 5'd5, 0, 5'd5, 1, 1, 0);
    cycle();
    set_id(6'h2b, 5'd9, 5'd5, 0, 5'd0, 0, 0, 1);
    #1 check("t3_no_rt", 160'(lu_stall), 160'(0));
    cycle();

    // Flush while frozen, then a single bubble on the next advance
    flush = 1; ihit = 0;
    cycle(); cycle();
    check("t4_hold", 160'(ex_op), 160'(6'h2b));
    flush = 0; ihit = 1;
    cycle();
    check("t4_bubble", 160'({ex_valid, bubble_cnt}), 160'({1'b0, 5'd3}));

    // dmem_wait freezes with a pending load-use; one bubble once released
    set_id(6'h23, 5'd1, 5'd5, 0, 5'd5, 1, 1, 0);
    cycle();
    set_id(6'd0, 5'd5, 5'd6, 1, 5'd7, 1, 0, 0);
    dmem_wait = 1;
    repeat (3) begin
      cycle();
      check("t5_stall", 160'({lu_stall, MemRead_ex}), 160'(2'b11));
    end
    dmem_wait = 0;
    cycle();
    check("t5_one_bubble", 160'({ex_valid, lu_stall}), 160'(2'b00));
    cycle();

    // Reset while in the load-use bubble
    set_id(6'h23, 5'd1, 5'd5, 0, 5'd5, 1, 1, 0);
    cycle();
    set_id(6'd0, 5'd5, 5'd6, 1, 5'd7, 1, 0, 0);
    cycle();
    do_reset();
    set_id(6'd0, 5'd5, 5'd6, 1, 5'd7, 1, 0, 0); ihit = 1;
    cycle();

    // Saturation via repeated flushes
    flush = 1;
    repeat (CNT_MAX + 3) cycle();
    check("t6_sat", 160'(bubble_cnt), 160'(CNT_MAX));
    flush = 0;

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        ihit       = ($urandom_range(0, 9) < 8);
        dmem_wait  = ($urandom_range(0, 9) < 2);
        flush      = ($urandom_range(0, 15) == 0);
        id_valid   = ($urandom_range(0, 9) < 9);
        id_op      = 6'($urandom);
        id_rs      = 5'($urandom_range(0, 3));
        id_rt      = 5'($urandom_range(0, 3));
        id_uses_rt = 1'($urandom);
        id_wsel    = 5'($urandom_range(0, 3));
        id_regwrite = 1'($urandom);
        id_memread = ($urandom_range(0, 2) == 0);
        id_memwrite = 1'($urandom);
        id_aluop   = 4'($urandom);
        id_rdat1   = $urandom; id_rdat2 = $urandom;
        id_imm     = $urandom; id_npc = $urandom;
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
